// File: rtl/rs_dispatch_queue_pkg.sv
// -----------------------------------------------------------------------------
// rs_dispatch_queue_pkg
//   Dispatch-side system definitions shared by rename, the dispatch queue and
//   the reservation-station bank.
//
//   MACHINE_WIDTH      : packets moved per cycle between rename and the RS bank.
//   DISPATCH_RS_PACKET : one renamed instruction; packet_valid marks an
//                        occupied lane, the remaining fields are payload.
// -----------------------------------------------------------------------------
package rs_dispatch_queue_pkg;

   localparam int unsigned MACHINE_WIDTH = 4;

   typedef struct packed {
      logic        packet_valid;
      logic [31:0] pc;
      logic [6:0]  opcode;
      logic [5:0]  dest_prn;
      logic [5:0]  src1_prn;
      logic [5:0]  src2_prn;
   } DISPATCH_RS_PACKET;

endpackage : rs_dispatch_queue_pkg

// File: rtl/rs_dispatch_queue_lead_one_cnt.sv
// -----------------------------------------------------------------------------
// lead_one_cnt
//   Counts the run of consecutive ones starting at bit 0 of bits_in.
//   0111 -> 3, 0101 -> 1, 1110 -> 0.
//
//   WIDTH    : width of the input vector.
//   bits_in  : in  [WIDTH-1:0]            vector to scan.
//   ones_cnt : out [$clog2(WIDTH+1)-1:0]  length of the leading run of ones.
// -----------------------------------------------------------------------------
module lead_one_cnt #(
   parameter  int unsigned WIDTH = 4,
   localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] bits_in,
   output logic [CNT_W-1:0] ones_cnt
);

   logic still_run;

   always_comb begin
      ones_cnt  = '0;
      still_run = 1'b1;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         // Once a zero is seen the run is over; later ones do not count.
         still_run = still_run & bits_in[i];
         ones_cnt  = ones_cnt + CNT_W'(still_run);
      end
   end

endmodule : lead_one_cnt

// File: rtl/rs_dispatch_queue.sv
// -----------------------------------------------------------------------------
// rs_dispatch_queue
//   Decoupling FIFO between rename and the reservation-station bank. Accepts up
//   to MACHINE_WIDTH packets per cycle and presents the oldest entries on the
//   dispatch lanes; dequeues the leading run of lanes the RS bank accepts.
//
//   Parameters:
//     DEPTH               queue entries, power of two, >= MACHINE_WIDTH.
//   Ports:
//     clk                 in   clock.
//     rst                 in   asynchronous active-high reset.
//     pipe_flush          in   discard all contents.
//     in_pkt[]            in   renamed packets, valid lanes contiguous from 0.
//     in_ready            out  a full group can be taken this cycle.
//     dispatch_pkt[]      out  oldest entries, lane 0 = oldest.
//     dispatch_pkt_ready  in   per-lane accept from the RS bank.
//     q_count             out  occupancy.
//     q_empty             out  q_count == 0.
//
//   Optional feature: define RS_DISPATCH_BYPASS_EN to let an empty queue
//   forward in_pkt straight onto dispatch_pkt in the same cycle.
// -----------------------------------------------------------------------------
module rs_dispatch_queue
   import rs_dispatch_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      pipe_flush,
   input  DISPATCH_RS_PACKET         in_pkt [0:MACHINE_WIDTH-1],
   output logic                      in_ready,
   output DISPATCH_RS_PACKET         dispatch_pkt [0:MACHINE_WIDTH-1],
   input  logic [MACHINE_WIDTH-1:0]  dispatch_pkt_ready,
   output logic [$clog2(DEPTH):0]    q_count,
   output logic                      q_empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned LW = $clog2(MACHINE_WIDTH + 1);

   // Registered state
   logic [AW-1:0]     head_q, head_d;
   logic [AW-1:0]     tail_q, tail_d;
   logic [CW-1:0]     count_q, count_d;
   DISPATCH_RS_PACKET mem_q [0:DEPTH-1];
   DISPATCH_RS_PACKET mem_d [0:DEPTH-1];

   // Per-cycle control
   logic [CW-1:0]            push_cnt;
   logic [CW-1:0]            pop_cnt;
   logic [LW-1:0]            pop_lanes;
   logic [CW-1:0]            wr_skip;
   logic [CW-1:0]            head_adv;
   logic [MACHINE_WIDTH-1:0] out_valid;
   logic [MACHINE_WIDTH-1:0] accept_mask;
   logic                     bypass_active;

   // --------------------------------------------------------------------------
   // Input side: readiness from registered state only, push = popcount.
   // --------------------------------------------------------------------------
   always_comb begin
      in_ready = !rst && !pipe_flush &&
                 ((CW'(DEPTH) - count_q) >= CW'(MACHINE_WIDTH));
      push_cnt = '0;
      if (in_ready) begin
         for (int unsigned i = 0; i < MACHINE_WIDTH; i++) begin
            push_cnt = push_cnt + CW'(in_pkt[i].packet_valid);
         end
      end
   end

   // --------------------------------------------------------------------------
   // Output lanes: lane i shows mem[head+i]; valid from count only, so the
   // RS bank's ready never feeds back into packet_valid.
   // --------------------------------------------------------------------------
   always_comb begin
      bypass_active = 1'b0;
      for (int unsigned i = 0; i < MACHINE_WIDTH; i++) begin
         dispatch_pkt[i]              = mem_q[head_q + AW'(i)];
         dispatch_pkt[i].packet_valid = !rst && !pipe_flush && (CW'(i) < count_q);
      end
`ifdef RS_DISPATCH_BYPASS_EN
      if (!rst && !pipe_flush && (count_q == '0)) begin
         bypass_active = 1'b1;
         for (int unsigned i = 0; i < MACHINE_WIDTH; i++) begin
            dispatch_pkt[i] = in_pkt[i];
         end
      end
`endif
   end

   always_comb begin
      for (int unsigned i = 0; i < MACHINE_WIDTH; i++) begin
         out_valid[i] = dispatch_pkt[i].packet_valid;
      end
      accept_mask = out_valid & dispatch_pkt_ready;
   end

   lead_one_cnt #(
      .WIDTH (MACHINE_WIDTH)
   ) u_pop_cnt (
      .bits_in  (accept_mask),
      .ones_cnt (pop_lanes)
   );

   assign pop_cnt = CW'(pop_lanes);

   // --------------------------------------------------------------------------
   // Next state. Bypassed lanes were consumed straight from in_pkt, so they
   // are skipped on the write side and head does not move; otherwise pops
   // advance head and every pushed lane is written.
   // --------------------------------------------------------------------------
   always_comb begin
      head_d   = head_q;
      tail_d   = tail_q;
      count_d  = count_q;
      mem_d    = mem_q;
      wr_skip  = bypass_active ? pop_cnt : '0;
      head_adv = bypass_active ? '0 : pop_cnt;
      if (pipe_flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         for (int unsigned i = 0; i < MACHINE_WIDTH; i++) begin
            if ((CW'(i) >= wr_skip) && (CW'(i) < push_cnt)) begin
               mem_d[tail_q + AW'(CW'(i) - wr_skip)] = in_pkt[i];
            end
         end
         tail_d  = tail_q + AW'(push_cnt - wr_skip);
         head_d  = head_q + AW'(head_adv);
         count_d = count_q + push_cnt - pop_cnt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         mem_q   <= mem_d;
      end
   end

   assign q_count = count_q;
   assign q_empty = (count_q == '0);

endmodule : rs_dispatch_queue

// File: tb/tb_rs_dispatch_queue.sv
// -----------------------------------------------------------------------------
// tb_rs_dispatch_queue
//   Directed bench for rs_dispatch_queue (DEPTH = 8, MACHINE_WIDTH = 4,
//   default build without the bypass). Packet id n carries pc 0x1000 + n.
// -----------------------------------------------------------------------------
module tb_rs_dispatch_queue;
   import rs_dispatch_queue_pkg::*;

   logic                     clk;
   logic                     rst;
   logic                     pipe_flush;
   DISPATCH_RS_PACKET        in_pkt [0:MACHINE_WIDTH-1];
   logic                     in_ready;
   DISPATCH_RS_PACKET        dispatch_pkt [0:MACHINE_WIDTH-1];
   logic [MACHINE_WIDTH-1:0] dispatch_pkt_ready;
   logic [3:0]               q_count;
   logic                     q_empty;

   int n_assert = 0;
   int n_fail   = 0;

   rs_dispatch_queue #(
      .DEPTH (8)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .pipe_flush         (pipe_flush),
      .in_pkt             (in_pkt),
      .in_ready           (in_ready),
      .dispatch_pkt       (dispatch_pkt),
      .dispatch_pkt_ready (dispatch_pkt_ready),
      .q_count            (q_count),
      .q_empty            (q_empty)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [3:0] v,
                          input int a, input int b, input int c, input int d);
      logic [3:0] mask;
      int         ids [4];
      ids = '{a, b, c, d};
      for (int i = 0; i < 4; i++) mask[i] = dispatch_pkt[i].packet_valid;
      chk({tag, "_valid"}, 64'(mask), 64'(v));
      for (int i = 0; i < 4; i++) begin
         if (v[i]) chk($sformatf("%s_lane%0d", tag, i), 64'(dispatch_pkt[i].pc),
                       64'(32'h1000 + ids[i]));
      end
   endtask

   // Lanes 0..n-1 valid with ids base, base+1, ...; remaining lanes empty.
   task automatic drive(input int n, input int base);
      for (int i = 0; i < 4; i++) begin
         in_pkt[i] = '0;
         if (i < n) begin
            in_pkt[i].packet_valid = 1'b1;
            in_pkt[i].pc           = 32'h1000 + base + i;
            in_pkt[i].opcode       = 7'(base + i);
            in_pkt[i].dest_prn     = 6'(base + i);
         end
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst                = 1'b1;
      pipe_flush         = 1'b0;
      dispatch_pkt_ready = 4'b0000;
      drive(0, 0);

      // Reset values
      #2;
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_count", 64'(q_count), 64'd0);
      chk("rst_empty", 64'(q_empty), 64'd1);
      chk_out("rst_out", 4'b0000, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);

      // Basic pass-through: 1..4 pushed, visible next cycle, popped with 1111
      drive(4, 1); dispatch_pkt_ready = 4'b1111;
      #1 chk_out("pt_same_cycle", 4'b0000, 0, 0, 0, 0);
      cyc(); drive(0, 0);
      #1 chk("pt_count4", 64'(q_count), 64'd4);
      chk_out("pt_lanes", 4'b1111, 1, 2, 3, 4);
      cyc();
      #1 chk("pt_count0", 64'(q_count), 64'd0);
      chk("pt_empty", 64'(q_empty), 64'd1);
      chk_out("pt_drained", 4'b0000, 0, 0, 0, 0);

      // Fill to full, third group ignored
      dispatch_pkt_ready = 4'b0000;
      drive(4, 5);
      cyc(); drive(4, 9);
      #1 chk("fill_count4", 64'(q_count), 64'd4);
      chk("fill_ready4", 64'(in_ready), 64'd1);
      cyc(); drive(4, 13);
      #1 chk("fill_count8", 64'(q_count), 64'd8);
      chk("fill_full_ready", 64'(in_ready), 64'd0);
      cyc(); drive(0, 0);
      #1 chk("fill_ignored", 64'(q_count), 64'd8);
      chk_out("fill_lanes", 4'b1111, 5, 6, 7, 8);
      dispatch_pkt_ready = 4'b1111;
      cyc(); dispatch_pkt_ready = 4'b0000;
      #1 chk("drain_count", 64'(q_count), 64'd4);
      chk("drain_in_ready", 64'(in_ready), 64'd1);
      chk_out("drain_lanes", 4'b1111, 9, 10, 11, 12);

      // Partial accept: 0011 pops two, 0101 pops one
      dispatch_pkt_ready = 4'b0011;
      cyc(); dispatch_pkt_ready = 4'b0000;
      #1 chk("part_count2", 64'(q_count), 64'd2);
      chk_out("part_lanes", 4'b0011, 11, 12, 0, 0);
      dispatch_pkt_ready = 4'b0101;
      cyc(); dispatch_pkt_ready = 4'b0000;
      #1 chk("nonprefix_count", 64'(q_count), 64'd1);
      chk_out("nonprefix_lanes", 4'b0001, 12, 0, 0, 0);

      // Count 5, then flush with a concurrent push
      drive(4, 17);
      cyc(); drive(0, 0);
      #1 chk("pre_flush_count", 64'(q_count), 64'd5);
      chk_out("pre_flush_lanes", 4'b1111, 12, 17, 18, 19);
      pipe_flush = 1'b1; drive(4, 21); dispatch_pkt_ready = 4'b1111;
      #1 chk("flush_in_ready", 64'(in_ready), 64'd0);
      chk_out("flush_out", 4'b0000, 0, 0, 0, 0);
      cyc(); pipe_flush = 1'b0; drive(0, 0); dispatch_pkt_ready = 4'b0000;
      #1 chk("post_flush_count", 64'(q_count), 64'd0);
      chk("post_flush_empty", 64'(q_empty), 64'd1);
      chk("post_flush_ready", 64'(in_ready), 64'd1);

      // Wrap-around: move head to 6 with entries at slots 6, 7, 0, 1
      drive(4, 30);
      cyc(); drive(4, 34);
      cyc(); drive(0, 0); dispatch_pkt_ready = 4'b1111;
      #1 chk("wrap_full", 64'(q_count), 64'd8);
      cyc(); dispatch_pkt_ready = 4'b0011;
      #1 chk_out("wrap_half", 4'b1111, 34, 35, 36, 37);
      cyc(); dispatch_pkt_ready = 4'b0000; drive(2, 40);
      #1 chk("wrap_head6_count", 64'(q_count), 64'd2);
      chk_out("wrap_head6", 4'b0011, 36, 37, 0, 0);
      cyc(); drive(0, 0);
      #1 chk("wrap_count4", 64'(q_count), 64'd4);
      chk_out("wrap_lanes", 4'b1111, 36, 37, 40, 41);
      dispatch_pkt_ready = 4'b1111;
      cyc(); dispatch_pkt_ready = 4'b0000;
      #1 chk("wrap_popped", 64'(q_count), 64'd0);
      drive(4, 50);
      cyc(); drive(0, 0);
      #1 chk_out("wrap_head2", 4'b1111, 50, 51, 52, 53);

      // Simultaneous push 3 / pop 4
      drive(3, 60); dispatch_pkt_ready = 4'b1111;
      cyc(); drive(0, 0); dispatch_pkt_ready = 4'b0000;
      #1 chk("pushpop_count", 64'(q_count), 64'd3);
      chk_out("pushpop_lanes", 4'b0111, 60, 61, 62, 0);

      // Asynchronous reset mid-operation
      rst = 1'b1;
      #1 chk("midrst_count", 64'(q_count), 64'd0);
      chk("midrst_empty", 64'(q_empty), 64'd1);
      chk("midrst_in_ready", 64'(in_ready), 64'd0);
      chk_out("midrst_out", 4'b0000, 0, 0, 0, 0);
      @(negedge clk); rst = 1'b0;
      #1 chk("midrst_release_ready", 64'(in_ready), 64'd1);
      drive(1, 70);
      cyc(); drive(0, 0);
      #1 chk("after_rst_count", 64'(q_count), 64'd1);
      chk_out("after_rst_lanes", 4'b0001, 70, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_rs_dispatch_queue
